// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite write master: FSM states,
// response codes and strobe-width derivation.
package axil_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } axil_wr_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage

// File: rtl/axil_valid_hold.sv
// Per-channel VALID holder: raises VALID on start, holds it until the READY
// handshake, then remembers that this channel has completed the attempt.
module axil_valid_hold (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic start_i,
  input  logic abort_i,
  input  logic ready_i,
  output logic valid_o,
  output logic done_o
);

  logic valid_q, valid_d;
  logic cmpl_q, cmpl_d;

  always_comb begin
    valid_d = valid_q;
    cmpl_d  = cmpl_q;
    if (abort_i) begin
      valid_d = 1'b0;
      cmpl_d  = 1'b0;
    end else if (start_i) begin
      valid_d = 1'b1;
      cmpl_d  = 1'b0;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      cmpl_d  = 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      valid_q <= 1'b0;
      cmpl_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cmpl_q  <= cmpl_d;
    end
  end

  assign valid_o = valid_q;
  // Completion includes the handshake happening this cycle so the FSM can move on next edge.
  assign done_o  = cmpl_q | (valid_q & ready_i);

endmodule

// File: rtl/axil_write_master.sv
// AXI4-Lite single-beat write master with bounded retry on SLVERR/DECERR.
// Optional response watchdog is built in when AXIL_WR_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// SEND  | AW/W beats outstanding from the holding registers
// RESP  | both beats accepted, BREADY high, waiting for B
// DONE  | one-cycle done_valid pulse with done_resp
module axil_write_master
  import axil_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int MAX_RETRY   = 2,
  parameter  int TIMEOUT_CYC = 256,
  localparam int STRB_W      = strb_width(DATA_W)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [STRB_W-1:0] cmd_strb,
  input  logic [2:0]        cmd_prot,
  output logic              done_valid,
  output logic [1:0]        done_resp,
  output logic              done_timeout,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [2:0]        AWPROT,
  output logic              WVALID,
  input  logic              WREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [1:0]        BRESP
);

  localparam logic [2:0] MAX_RETRY_L = 3'(MAX_RETRY);

  axil_wr_state_e    state_q, state_d;
  logic [2:0]        retry_q, retry_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [2:0]        prot_q, prot_d;
  logic [1:0]        resp_q, resp_d;
  logic              start, abort;
  logic              aw_cmpl, w_cmpl;

`ifdef AXIL_WR_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_q, tmo_d;
  logic             tmo_tc;

  assign tmo_tc = (tmo_cnt_q == '0);
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
`endif

  axil_valid_hold u_aw_hold (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .start_i (start),
    .abort_i (abort),
    .ready_i (AWREADY),
    .valid_o (AWVALID),
    .done_o  (aw_cmpl)
  );

  axil_valid_hold u_w_hold (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .start_i (start),
    .abort_i (abort),
    .ready_i (WREADY),
    .valid_o (WVALID),
    .done_o  (w_cmpl)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    resp_d  = resp_q;
    start   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          strb_d  = cmd_strb;
          prot_d  = cmd_prot;
          retry_d = 3'd0;
          start   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (aw_cmpl && w_cmpl) state_d = RESP;
      end
      RESP: begin
        if (BVALID) begin
          if (resp_is_err(BRESP) && (retry_q < MAX_RETRY_L)) begin
            retry_d = retry_q + 3'd1;
            start   = 1'b1;
            state_d = SEND;
          end else begin
            resp_d  = BRESP;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef AXIL_WR_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = tmo_q;
    // A B handshake landing on the terminal cycle still wins over the watchdog.
    if (tmo_tc && ((state_q == SEND) || ((state_q == RESP) && !BVALID))) begin
      state_d = DONE;
      resp_d  = DECERR;
      tmo_d   = 1'b1;
      abort   = 1'b1;
      start   = 1'b0;
    end
    if (start) begin
      tmo_cnt_d = TMO_W'(TIMEOUT_CYC - 1);
      tmo_d     = 1'b0;
    end else if (((state_q == SEND) || (state_q == RESP)) && !tmo_tc) begin
      tmo_cnt_d = tmo_cnt_q - 1'b1;
    end
`endif
  end

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      state_q <= IDLE;
      retry_q <= 3'd0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      prot_q  <= 3'd0;
      resp_q  <= OKAY;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      resp_q  <= resp_d;
    end
  end

`ifdef AXIL_WR_TIMEOUT_EN
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign done_timeout = tmo_q && (state_q == DONE);
`else
  assign done_timeout = 1'b0;
`endif

  // cmd_ready is gated by reset so it is low for the whole reset assertion.
  assign cmd_ready  = (state_q == IDLE) && !ARESETn;
  assign BREADY     = (state_q == RESP);
  assign done_valid = (state_q == DONE);
  assign done_resp  = resp_q;
  assign AWADDR     = addr_q;
  assign AWPROT     = prot_q;
  assign WDATA      = data_q;
  assign WSTRB      = strb_q;

endmodule

// File: tb/tb_axil_write_master.sv
// Self-checking bench for axil_write_master: directed cases plus randomized
// commands, slave delays and response sequences against a transaction-level model.
module tb_axil_write_master;

  localparam int MAXR = 2;
  localparam int TMO  = 16;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        done_valid, done_timeout;
  logic [1:0]  done_resp;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] AWADDR, WDATA;
  logic [2:0]  AWPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [1:0] rsp_seq [0:MAXR];

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  axil_write_master #(
    .ADDR_W(32), .DATA_W(32), .MAX_RETRY(MAXR), .TIMEOUT_CYC(TMO)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .done_valid(done_valid), .done_resp(done_resp), .done_timeout(done_timeout),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_rsp(input logic [1:0] r0, input logic [1:0] r1, input logic [1:0] r2);
    rsp_seq[0] = r0;
    rsp_seq[1] = r1;
    rsp_seq[2] = r2;
  endtask

  // Model: attempts stop at the first OKAY/EXOKAY or after MAXR retries.
  function automatic int exp_issues();
    for (int k = 0; k <= MAXR; k++)
      if (rsp_seq[k] == 2'b00 || rsp_seq[k] == 2'b01) return k + 1;
    return MAXR + 1;
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] p, input int awd, input int wd, input int bd);
    int n_exp, lat_exp, t0, budget;
    int aw_n, w_n, b_n, aw_c, w_c, b_c;
    bit seen_done, first_resp;
    n_exp   = exp_issues();
    lat_exp = n_exp * (((awd > wd) ? awd : wd) + 1 + bd + 1) + 1;
    budget  = 0;
    while (!cmd_ready && budget < 20) begin
      @(negedge ACLK);
      budget++;
    end
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_prot = p;
    t0 = cyc;
    @(negedge ACLK);
    cmd_valid = 1'b0; cmd_addr = ~a; cmd_data = ~d; cmd_strb = ~s; cmd_prot = ~p;
    aw_n = 0; w_n = 0; b_n = 0; aw_c = 0; w_c = 0; b_c = 0;
    seen_done = 1'b0; first_resp = 1'b1;
    for (int t = 0; t < 300 && !seen_done; t++) begin
      AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
      if (done_valid) begin
        seen_done = 1'b1;
        chk("done_resp", done_resp, rsp_seq[n_exp-1]);
        chk("done_timeout_low", done_timeout, 1'b0);
        chk("aw_issue_count", aw_n, n_exp);
        chk("w_issue_count", w_n, n_exp);
        chk("latency", cyc - t0, lat_exp);
        chk("no_accept_in_done", cmd_ready, 1'b0);
      end else begin
        if (AWVALID) begin
          chk("aw_beat", {AWADDR, AWPROT}, {a, p});
          if (aw_c >= awd) begin AWREADY = 1'b1; aw_n++; end
          aw_c++;
        end
        if (WVALID) begin
          chk("w_beat", {WDATA, WSTRB}, {d, s});
          if (w_c >= wd) begin WREADY = 1'b1; w_n++; end
          w_c++;
        end
        if (BREADY) begin
          if (first_resp) begin
            chk("resp_after_aw_w", {aw_n[7:0], w_n[7:0]}, {8'(b_n + 1), 8'(b_n + 1)});
            chk("no_valid_in_resp", {AWVALID, WVALID}, 2'b00);
            first_resp = 1'b0;
          end
          if (b_c >= bd) begin
            BVALID = 1'b1; BRESP = rsp_seq[b_n];
            b_n++; b_c = 0; aw_c = 0; w_c = 0; first_resp = 1'b1;
          end else begin
            b_c++;
          end
        end
      end
      @(negedge ACLK);
    end
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
    if (!seen_done) chk("done_seen_in_budget", 1'b0, 1'b1);
  endtask

  task automatic idle_gap(input int n);
    for (int g = 0; g < n; g++) begin
      BVALID = 1'b1;
      BRESP  = 2'($urandom_range(0, 3));
      @(negedge ACLK);
      chk("stray_b_ignored", {done_valid, BREADY, cmd_ready}, 3'b001);
    end
    BVALID = 1'b0;
  endtask

  initial begin
    bit saw;
    int t_send, aw_seen;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0; cmd_prot = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("rst_outputs", {AWVALID, WVALID, BREADY, done_valid, done_timeout, done_resp, cmd_ready}, 8'h00);
    chk("rst_awaddr", AWADDR, 32'h0);
    chk("rst_wdata_strb_prot", {WDATA, WSTRB, AWPROT}, 39'h0);
    ARESETn = 1'b0;
    #1 chk("ready_after_rst", cmd_ready, 1'b1);
    @(negedge ACLK);

    set_rsp(2'b00, 2'b00, 2'b00);
    run_txn(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 0, 0);
    idle_gap(2);
    set_rsp(2'b00, 2'b00, 2'b00);
    run_txn(32'h0000_2004, 32'h1234_5678, 4'h3, 3'd2, 4, 0, 1);
    set_rsp(2'b10, 2'b10, 2'b10);
    run_txn(32'h0000_3008, 32'hCAFE_F00D, 4'hC, 3'd5, 0, 0, 0);
    set_rsp(2'b10, 2'b00, 2'b00);
    run_txn(32'h0000_400C, 32'h0BAD_CAFE, 4'h1, 3'd7, 0, 2, 0);
    set_rsp(2'b11, 2'b01, 2'b00);
    run_txn(32'h0000_5010, 32'h5555_AAAA, 4'h6, 3'd1, 1, 3, 2);

    cmd_addr = 32'hA5A5_0000; cmd_data = 32'h0F0F_0F0F; cmd_strb = 4'hF; cmd_prot = 3'd0;
    cmd_valid = 1'b1;
    @(negedge ACLK);
    cmd_valid = 1'b0; AWREADY = 1'b1; WREADY = 1'b1;
    @(negedge ACLK);
    AWREADY = 1'b0; WREADY = 1'b0;
    chk("pre_rst_in_resp", BREADY, 1'b1);
    BVALID = 1'b1; BRESP = 2'b00;
    ARESETn = 1'b1;
    #1 chk("mid_rst_cleared", {AWVALID, WVALID, BREADY, done_valid, done_timeout, done_resp, cmd_ready}, 8'h00);
    saw = 1'b0;
    repeat (2) begin
      @(negedge ACLK);
      if (done_valid) saw = 1'b1;
    end
    BVALID = 1'b0;
    ARESETn = 1'b0;
    #1 chk("rst_release_ready", cmd_ready, 1'b1);
    repeat (3) begin
      @(negedge ACLK);
      if (done_valid) saw = 1'b1;
    end
    chk("no_done_after_rst", saw, 1'b0);

    for (int i = 0; i < 40; i++) begin
      set_rsp(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      run_txn($urandom, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      idle_gap($urandom_range(0, 2));
    end

`ifdef AXIL_WR_TIMEOUT_EN
    cmd_addr = 32'h0000_7000; cmd_data = 32'h7777_7777; cmd_strb = 4'hF; cmd_prot = 3'd0;
    cmd_valid = 1'b1;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    @(negedge ACLK);
    t_send = cyc;
    AWREADY = 1'b1; WREADY = 1'b1;
    aw_seen = 0;
    saw = 1'b0;
    for (int t = 0; t < 60 && !saw; t++) begin
      @(negedge ACLK);
      AWREADY = 1'b0; WREADY = 1'b0;
      if (AWVALID) aw_seen++;
      if (done_valid) begin
        saw = 1'b1;
        chk("tmo_latency", cyc - t_send, TMO);
        chk("tmo_resp", done_resp, 2'b11);
        chk("tmo_flag", done_timeout, 1'b1);
        chk("tmo_outputs_low", {AWVALID, WVALID, BREADY}, 3'b000);
        chk("tmo_no_retry", aw_seen, 0);
      end
    end
    if (!saw) chk("tmo_done_seen", 1'b0, 1'b1);
    @(negedge ACLK);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axil_write_master.md
AXIL_WRITE_MASTER -- requirements
Module: axil_write_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (32 or 64); STRB_W = DATA_W/8.
REQ-003 SHALL have parameter MAX_RETRY, default 2, re-issues allowed after SLVERR/DECERR (0..7).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 256, response watchdog limit in cycles (used only under AXIL_WR_TIMEOUT_EN).
REQ-005 SHALL have the port ACLK, input, 1 bit: clock, rising edge.
REQ-006 SHALL have the port ARESETn, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have the command ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_addr (in, ADDR_W), cmd_data (in, DATA_W), cmd_strb (in, STRB_W) and cmd_prot (in, 3).
REQ-008 SHALL have the completion ports done_valid (out, 1), done_resp (out, 2) and done_timeout (out, 1).
REQ-009 SHALL have the AW channel ports AWVALID (out, 1), AWREADY (in, 1), AWADDR (out, ADDR_W) and AWPROT (out, 3).
REQ-010 SHALL have the W channel ports WVALID (out, 1), WREADY (in, 1), WDATA (out, DATA_W) and WSTRB (out, STRB_W).
REQ-011 SHALL have the B channel ports BVALID (in, 1), BREADY (out, 1) and BRESP (in, 2).

Function
REQ-012 SHALL implement states IDLE, SEND, RESP, DONE.
REQ-013 SHALL assert cmd_ready only in IDLE; when cmd_valid && cmd_ready, capture addr/data/strb/prot into holding registers, clear the retry count, and enter SEND next cycle.
REQ-014 SHALL, on entering SEND, assert AWVALID and WVALID together, driving AWADDR/AWPROT/WDATA/WSTRB from the holding registers, stable while VALID is high.
REQ-015 SHALL drop AWVALID the cycle after AWVALID&&AWREADY, and WVALID the cycle after WVALID&&WREADY, each independently; either channel may complete first, or both may complete in the same cycle.
REQ-016 SHALL leave SEND for RESP in the cycle after both handshakes have completed; VALID SHALL never depend combinationally on READY.
REQ-017 SHALL assert BREADY only in RESP; on BVALID&&BREADY with BRESP 00/01, enter DONE with done_resp=BRESP.
REQ-018 SHALL, on BRESP 10/11 with retry count < MAX_RETRY, increment the retry count and re-enter SEND, reissuing identical AW/W beats.
REQ-019 SHALL, on BRESP 10/11 with retry count == MAX_RETRY, enter DONE with done_resp=BRESP.
REQ-020 SHALL pulse done_valid for exactly one cycle in DONE, with done_resp valid in that cycle, then return to IDLE; the next command is accepted no earlier than 1 cycle after DONE.
REQ-021 SHALL ignore BVALID outside RESP.
REQ-022 SHALL give a best-case latency of 3 cycles from command accept to done_valid (AW/W ready immediately, B on the following cycle).

Reset
REQ-023 SHALL, while ARESETn=1, immediately force state IDLE and AWVALID=WVALID=BREADY=done_valid=done_timeout=0, done_resp=00, cmd_ready=0, and clear the retry count and timeout counter.
REQ-024 SHALL drive cmd_ready=1 in the first clock after ARESETn deasserts; a reset mid-transaction SHALL abandon the transaction without issuing done_valid.
REQ-025 SHALL reset the holding registers to 0.

Configuration
REQ-026 SHALL, with AXIL_WR_TIMEOUT_EN defined, count cycles spent in SEND+RESP per attempt; when the count reaches TIMEOUT_CYC, drop all VALID/READY outputs, enter DONE with done_resp=11 and done_timeout=1, and perform no retry.
REQ-027 SHALL, without AXIL_WR_TIMEOUT_EN, remove the counter, tie done_timeout to 0, and wait indefinitely.

Structure
REQ-028 SHALL place the state enum, the response constants (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and the STRB_W derivation in the shared package axil_pkg.
REQ-029 SHALL isolate the per-channel VALID hold/drop logic in one sub-module axil_valid_hold, instantiated for AW and W.

Verification
REQ-030 SHALL cover: cmd addr=0x1000, data=0xDEADBEEF, strb=F; AWREADY/WREADY=1, BVALID=1 with BRESP=00 one cycle later -> done_valid 3 cycles after accept, done_resp=00.
REQ-031 SHALL cover: WREADY 4 cycles before AWREADY -> WVALID drops first, AWVALID holds with AWADDR stable; RESP is entered only after AW completes.
REQ-032 SHALL cover: BRESP=10 three times with MAX_RETRY=2 -> exactly 3 AW/W issues, then done_resp=10.
REQ-033 SHALL cover: BRESP=10 then 00 -> 2 issues, done_resp=00.
REQ-034 SHALL cover: ARESETn pulsed while in RESP -> outputs cleared immediately, no done_valid, cmd_ready=1 after release.
REQ-035 SHALL cover (AXIL_WR_TIMEOUT_EN, TIMEOUT_CYC=16): BVALID never asserted -> done_valid with done_resp=11 and done_timeout=1, 16 cycles after SEND entry.
